// File: rtl/sum_serial_pkg.sv
// Shared types for the serial nibble adder.
// State encoding plus the WIDTH/NIBBLE legality check.
package sum_serial_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic bit width_ok(input int w, input int n);
      return (n > 0) && (w >= n) && ((w % n) == 0);
   endfunction

endpackage

// File: rtl/sum_slice.sv
// One W-bit adder slice with carry in/out.
// Reused every cycle by the serial adder.
module sum_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] s,
   output logic         co
);

   logic [W:0] t;

   assign t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
   assign co = t[W];
   assign s  = t[W-1:0];

endmodule

// File: rtl/sum_serial_nibble.sv
// Multi-cycle add/sub, NIBBLE bits per clock through one slice.
// start/done handshake; results held until next completion.
module sum_serial_nibble
   import sum_serial_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int NIBBLE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c0,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             c4,
   output logic             ovf
);

   localparam int NSLICE = WIDTH / NIBBLE;
   localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

   generate
      if (!width_ok(WIDTH, NIBBLE)) begin : g_bad_width
         $error("sum_serial_nibble: WIDTH must be a multiple of NIBBLE");
      end
   endgenerate

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] p_q;
   logic [WIDTH-1:0] p_nx;
   logic             cy_q;
   logic [IW-1:0]    idx_q;
   logic [NIBBLE-1:0] sl_a;
   logic [NIBBLE-1:0] sl_b;
   logic [NIBBLE-1:0] sl_s;
   logic             sl_co;
   logic             last;

   assign last = (idx_q == LAST);
   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);

   // Constant-index slice mux keeps the part-selects static.
   always_comb begin
      sl_a = '0;
      sl_b = '0;
      p_nx = p_q;
      for (int i = 0; i < NSLICE; i++) begin
         if (idx_q == IW'(i)) begin
            sl_a = a_q[i*NIBBLE +: NIBBLE];
            sl_b = b_q[i*NIBBLE +: NIBBLE];
            p_nx[i*NIBBLE +: NIBBLE] = sl_s;
         end
      end
   end

   sum_slice #(
      .W (NIBBLE)
   ) u_slice (
      .a  (sl_a),
      .b  (sl_b),
      .ci (cy_q),
      .s  (sl_s),
      .co (sl_co)
   );

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (last)  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q   <= '0;
         b_q   <= '0;
         p_q   <= '0;
         cy_q  <= 1'b0;
         idx_q <= '0;
         s     <= '0;
         c4    <= 1'b0;
         ovf   <= 1'b0;
      end else if ((state_q == ST_IDLE) && start) begin
         a_q   <= a;
         b_q   <= b ^ {WIDTH{sub}};
         cy_q  <= sub ? 1'b1 : c0;
         idx_q <= '0;
         p_q   <= '0;
      end else if (state_q == ST_RUN) begin
         p_q  <= p_nx;
         cy_q <= sl_co;
         if (last) begin
            s   <= p_nx;
            c4  <= sl_co;
            ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                   (p_nx[WIDTH-1] != a_q[WIDTH-1]);
         end else begin
            idx_q <= idx_q + 1'b1;
         end
      end
   end

endmodule
